ex_muldiv_unit: RTL and testbench



---
 rtl/ex_muldiv_pkg.sv | 39 +++
 rtl/ex_muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared types and decode helpers for the EX-stage RV32M multiply/divide unit.
//   muldiv_op_t    : funct3 encodings of the eight M-extension operations
//   muldiv_state_t : sequencer states
//   is_div / is_signed_a / is_signed_b : operation class and operand signedness
package ex_muldiv_pkg;

  localparam int unsigned MuldivXlen = 32;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } muldiv_state_t;

  function automatic logic is_div(muldiv_op_t op);
    return op inside {OpDiv, OpDivu, OpRem, OpRemu};
  endfunction

  // MUL is treated as unsigned: the low half of the product is sign-agnostic.
  function automatic logic is_signed_a(muldiv_op_t op);
    return op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
  endfunction

  function automatic logic is_signed_b(muldiv_op_t op);
    return op inside {OpMulh, OpDiv, OpRem};
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Multiplies with a right-shifting shift-add over a 2*XLEN accumulator and divides with a
// restoring divider that reuses the same accumulator as {remainder, quotient}. Operands are
// converted to magnitudes on acceptance and the result sign is fixed on the last step.
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : EX holds a valid M instruction (held high while stalled)
//   flush_i    : kill the in-flight operation
//   op_i       : funct3 of the instruction
//   a_i, b_i   : forwarded rs1 / rs2
//   stall_o    : freeze IF/ID/EX while the operation is accepted or running
//   busy_o     : sequencer not idle
//   done_o     : one-cycle result-valid pulse
//   result_o   : result, held until the next accepted start
module ex_muldiv_unit
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = MuldivXlen
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned     CntW    = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);

  muldiv_state_t     state_q, state_d;
  muldiv_op_t        op_q, op_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   opa_q, opa_d;     // |a|, multiplicand
  logic [XLEN-1:0]   opb_q, opb_d;     // |b|, multiplier (shifts right) or divisor
  logic [2*XLEN-1:0] acc_q, acc_d;     // product, or {remainder, dividend/quotient}
  logic              neg_q, neg_d;     // negate the selected result at the end
  logic [XLEN-1:0]   result_q, result_d;

  // Acceptance-time decode
  muldiv_op_t      op_in;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_zero, div_ovf;

  assign op_in    = muldiv_op_t'(op_i);
  assign a_neg    = is_signed_a(op_in) & a_i[XLEN-1];
  assign b_neg    = is_signed_b(op_in) & b_i[XLEN-1];
  assign a_abs    = a_neg ? -a_i : a_i;
  assign b_abs    = b_neg ? -b_i : b_i;
  assign div_zero = (b_i == '0);
  assign div_ovf  = is_signed_a(op_in) && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);

  // One multiply step: add the multiplicand into the upper half, then shift right.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (opb_q[0] ? opa_q : '0)};
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // One restoring divide step: shift the next dividend bit into the remainder and try a
  // subtract; the borrow bit decides the quotient bit.
  logic [XLEN:0]     div_rem, div_diff;
  logic [2*XLEN-1:0] div_next;

  assign div_rem  = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff = div_rem - {1'b0, opb_q};
  assign div_next = div_diff[XLEN] ? {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  // Final result selection with sign fix
  logic [2*XLEN-1:0] step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_sel;
  logic [XLEN-1:0]   fin;

  assign step     = is_div(op_q) ? div_next : mul_next;
  // The full product is negated so the high half carries the borrow from the low half.
  assign prod_fix = neg_q ? -step : step;
  assign div_sel  = op_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];

  always_comb begin
    fin = '0;
    unique case (op_q)
      OpMul:                     fin = prod_fix[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: fin = prod_fix[2*XLEN-1:XLEN];
      OpDiv, OpDivu, OpRem, OpRemu: fin = neg_q ? -div_sel : div_sel;
      default:                   fin = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;

    if (flush_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            op_d  = op_in;
            opa_d = a_abs;
            opb_d = b_abs;
            cnt_d = '0;
            // Remainder follows the dividend; everything else is sign(a) ^ sign(b).
            neg_d = (is_div(op_in) && op_in[1]) ? a_neg : (a_neg ^ b_neg);
            acc_d = is_div(op_in) ? {{XLEN{1'b0}}, a_abs} : '0;
            if (is_div(op_in) && div_zero) begin
              result_d = op_in[1] ? a_i : '1;
              state_d  = StDone;
            end else if (is_div(op_in) && div_ovf) begin
              result_d = op_in[1] ? '0 : a_i;
              state_d  = StDone;
            end else begin
              state_d = StBusy;
            end
          end
        end
        StBusy: begin
          acc_d = step;
          cnt_d = cnt_q + CntW'(1);
          if (!is_div(op_q)) begin
            opb_d = opb_q >> 1;
          end
          if (cnt_q == CntLast) begin
            result_d = fin;
            state_d  = StDone;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign stall_o  = ((state_q == StIdle) && start_i && !flush_i) || (state_q == StBusy);
  assign busy_o   = (state_q != StIdle);
  assign done_o   = (state_q == StDone);
  assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        flush_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int          n_cmp;
  int          n_err;
  logic [31:0] sb_q[$];
  logic [31:0] last_result;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .flush_i (flush_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .stall_o (stall_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .result_o(result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return op[2] && ((b == 32'h0) ||
                     (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0]        ea, eb, p;
    logic signed [31:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ea  = {{32{a[31]}}, a};
    eb  = {{32{b[31]}}, b};
    case (op)
      3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      3'd1: begin p = ea * eb; return p[63:32]; end
      3'd2: begin p = ea * {32'h0, b}; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Called aligned to a falling edge; returns aligned to a falling edge. With hold set,
  // start_i stays high after done so a following op can be issued back-to-back.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit hold, input string name);
    int          lat;
    int          done_cnt;
    int          done_cyc;
    bit          stall_bad;
    logic        exp_stall;
    logic [31:0] got_exp;
    lat = is_special(op, a, b) ? 1 : 33;
    start_i = 1'b1; flush_i = 1'b0; op_i = op; a_i = a; b_i = b;
    sb_q.push_back(exp);
    done_cnt = 0; done_cyc = -1; stall_bad = 1'b0;
    for (int c = 0; c <= lat; c++) begin
      #1;
      if (c == 0) begin
        n_cmp++;
        if (busy_o !== 1'b0) begin
          n_err++;
          $display("FAIL %s busy_at_accept: got %b want 0", name, busy_o);
        end
      end
      exp_stall = (c < lat);
      if (stall_o !== exp_stall) stall_bad = 1'b1;
      if (done_o === 1'b1) begin
        done_cnt++;
        done_cyc = c;
        if (sb_q.size() > 0) begin
          got_exp = sb_q.pop_front();
          n_cmp++;
          if (result_o !== got_exp) begin
            n_err++;
            $display("FAIL %s result: got %h want %h", name, result_o, got_exp);
          end
        end
      end
      // Operands must not be re-sampled after acceptance.
      if (c >= 1 && c < lat) begin
        a_i = $urandom;
        b_i = $urandom;
      end
      @(negedge clk);
    end
    if (done_cnt == 0 && sb_q.size() > 0) got_exp = sb_q.pop_front();
    n_cmp++;
    if (done_cnt !== 1) begin
      n_err++;
      $display("FAIL %s done_count: got %0d want 1", name, done_cnt);
    end
    n_cmp++;
    if (done_cyc !== lat) begin
      n_err++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, lat);
    end
    n_cmp++;
    if (stall_bad !== 1'b0) begin
      n_err++;
      $display("FAIL %s stall_window: got bad want cycles 0..%0d only", name, lat - 1);
    end
    last_result = exp;
    if (!hold) begin
      start_i = 1'b0;
      #1;
      n_cmp++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== exp) begin
        n_err++;
        $display("FAIL %s after_done: got done=%b busy=%b res=%h want 0 0 %h",
                 name, done_o, busy_o, result_o, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = 3'd0; a_i = '0; b_i = '0;
    #3;
    n_cmp++;
    if (stall_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: got stall=%b busy=%b done=%b res=%h want 0 0 0 0",
               stall_o, busy_o, done_o, result_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7xm3");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "mulh_min");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu_max");
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhsu_m1");
  endtask

  task automatic test_div();
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, "rem_m7_2");
    do_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b0, "divu_100_7");
    do_op(3'd7, 32'd100, 32'd7, 32'd2, 1'b0, "remu_100_7");
  endtask

  task automatic test_special();
    do_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, "divu_by0");
    do_op(3'd6, 32'd5, 32'd0, 32'd5, 1'b0, "rem_by0");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "div_ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, "rem_ovf");
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 3'(i);
      a  = $urandom;
      b  = (i == 7) ? 32'($urandom_range(1, 50)) : $urandom;
      do_op(op, a, b, ref_md(op, a, b), 1'b0, "random");
    end
  endtask

  task automatic test_flush();
    bit done_seen;
    bit res_moved;
    start_i = 1'b1; flush_i = 1'b0; op_i = 3'd0; a_i = 32'd7; b_i = 32'd3;
    for (int c = 0; c < 10; c++) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; start_i = 1'b0;
    #1;
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_busy: got %b want 0", busy_o);
    end
    done_seen = 1'b0; res_moved = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done_o !== 1'b0) done_seen = 1'b1;
      if (result_o !== last_result) res_moved = 1'b1;
      @(negedge clk);
      #1;
    end
    n_cmp++;
    if (done_seen !== 1'b0) begin
      n_err++;
      $display("FAIL flush_no_done: got done pulse want none");
    end
    n_cmp++;
    if (res_moved !== 1'b0) begin
      n_err++;
      $display("FAIL flush_result_held: got %h want %h", result_o, last_result);
    end
    @(negedge clk);
    // Start and flush together in IDLE: not accepted.
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'd5; a_i = 32'd9; b_i = 32'd3;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_start_stall: got %b want 0", stall_o);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_start_busy: got %b want 0", busy_o);
    end
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    do_op(3'd5, 32'd9, 32'd3, 32'd3, 1'b0, "divu_after_flush");
  endtask

  task automatic test_back_to_back();
    do_op(3'd0, 32'd6, 32'd9, 32'd54, 1'b1, "b2b_mul");
    do_op(3'd5, 32'd1000, 32'd10, 32'd100, 1'b0, "b2b_divu");
  endtask

  task automatic test_reset_mid();
    bit done_seen;
    start_i = 1'b1; flush_i = 1'b0; op_i = 3'd5; a_i = 32'd100; b_i = 32'd7;
    for (int c = 0; c < 20; c++) @(negedge clk);
    #2;
    rst_n = 1'b0; start_i = 1'b0;
    #1;
    n_cmp++;
    if (stall_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid: got stall=%b busy=%b done=%b res=%h want 0 0 0 0",
               stall_o, busy_o, done_o, result_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (done_o !== 1'b0 || busy_o !== 1'b0) done_seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (done_seen !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_quiet: got activity after reset want none");
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    last_result = 32'h0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_random();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (sb_q.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
